next_pc_ctrl: RTL and testbench
===============================

// Module: next_pc_ctrl
// PURPOSE
//  Next-PC scheduler for the fetch stage; drives PC_Write and new_pc of the program counter.
//  Arbitrates sequential fetch, ID-stage jumps, EX-stage branches, traps and mret.
//  Buffers a redirect that arrives during a cache stall and replays it when the stall clears.
//  Emits IF/ID flush pulses and holds the exception PC and cause registers.
// PARAMETERS
//  RESET_PC  32'h0000_0000  new_pc value presented while in reset
//  TRAP_VEC  32'h0000_1000  trap handler entry address
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   synchronous active-low reset (0 = reset), sampled on clk rising edge
//  hazard_stall  in   1   load-use stall from hazard unit
//  icache_stall  in   1   ICache miss stall
//  dcache_stall  in   1   DCache miss stall
//  pc_cur        in   32  current PC from PC register
//  jmp_valid     in   1   ID-stage jump resolved
//  jmp_target    in   32  jump target
//  br_taken      in   1   EX-stage branch taken
//  br_target     in   32  branch target
//  trap_req      in   1   exception/ecall request
//  trap_epc      in   32  PC of trapping instruction
//  trap_cause    in   4   cause code
//  mret_req      in   1   return from trap
//  pc_write      out  1   1 = PC loads new_pc at next edge
//  new_pc        out  32  next PC value
//  flush_if      out  1   kill IF/ID register contents
//  flush_id      out  1   kill ID/EX register contents
//  epc           out  32  saved exception PC
//  mcause        out  4   saved cause
//  ctrl_state    out  1   0 = RUN, 1 = HOLD
// BEHAVIOUR
//  - Reset (rst=0): state RUN, pend_valid=0, epc=0, mcause=0.
//    Outputs forced: pc_write=0, flush_if=0, flush_id=0, new_pc=RESET_PC.
//  - cstall = icache_stall | dcache_stall.
//  - Priority: trap(3) > mret(2) > br(1) > jmp(0); losers that cycle are dropped.
//  - Targets: trap -> TRAP_VEC; mret -> epc; br -> br_target; jmp -> jmp_target.
//  - epc<=trap_epc and mcause<=trap_cause whenever trap_req=1, including under stall.
//  - RUN, no request: pc_write = !(hazard_stall | cstall); new_pc = pc_cur+4 (mod 2^32).
//  - RUN, request, cstall=0: applied combinationally in the same cycle.
//    pc_write=1 (overrides hazard_stall); new_pc=target; flush_if=1.
//    flush_id=1 for trap, mret, br; flush_id=0 for jmp.
//  - RUN, request, cstall=1: latch pend_target/pend_prio/pend_valid; go to HOLD.
//    Outputs: pc_write=0, no flush.
//  - HOLD, cstall=1: pc_write=0. A new request with prio >= pend_prio overwrites the pending one.
//  - HOLD, cstall=0: apply the winner of {pending, new request}; the new request wins ties.
//    pc_write=1; one-cycle flush pulse per rules above; clear pend_valid; go to RUN.
//  - Flushes are single-cycle pulses, never asserted while pc_write=0.
//  - Reset mid-HOLD discards the pending redirect.
// CONFIGURATION
//  NEXT_PC_PERF_CNT_EN defined: adds outputs redirect_cnt[31:0] and stall_cnt[31:0].
//   - redirect_cnt: +1 per applied redirect.
//   - stall_cnt: +1 per cycle with pc_write=0 outside reset.
//   - Both saturate at 32'hFFFF_FFFF and reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. rst=0 for 2 cycles, then rst=1 with pc_cur=0: pc_write=0, flushes 0, epc=0, state RUN during reset;
//     after release new_pc=4, pc_write=1.
//  2. pc_cur=0x100, br_taken=1, br_target=0x40, no stalls:
//     same cycle new_pc=0x40, pc_write=1, flush_if=flush_id=1; next cycle flushes 0.
//  3. icache_stall=1 for 3 cycles, br_taken pulse (target 0x40) in cycle 1:
//     pc_write=0, state HOLD; in the cycle the stall drops, new_pc=0x40, pc_write=1, one flush pulse, state RUN.
//  4. trap_req (epc 0x200, cause 4'h2) + br_taken + jmp_valid together:
//     new_pc=0x1000, epc=0x200, mcause=2; later mret_req -> new_pc=0x200, flush_id=1.
//  5. hazard_stall=1 alone: pc_write=0.
//     hazard_stall=1 + jmp_valid (target 0x80): pc_write=1, new_pc=0x80, flush_if=1, flush_id=0.
//  6. pc_cur=0xFFFF_FFFC, no request: new_pc=0.
//     With NEXT_PC_PERF_CNT_EN, after test 3: stall_cnt=3, redirect_cnt=1.

Source files
------------

// File: rtl/next_pc_ctrl.sv
// Next-PC scheduler for the fetch stage: arbitrates sequential fetch, jumps, branches,
// traps and mret, buffering a redirect across cache stalls. Optional: NEXT_PC_PERF_CNT_EN.
module next_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic [31:0] pc_cur,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic [31:0] trap_epc,
  input  logic [3:0]  trap_cause,
  input  logic        mret_req,
  output logic        pc_write,
  output logic [31:0] new_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] epc,
  output logic [3:0]  mcause,
  output logic        ctrl_state
`ifdef NEXT_PC_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [1:0]  pend_prio;

  logic        cstall;
  logic        req;
  logic [1:0]  req_prio;
  logic [31:0] req_target;
  logic        latch_req;
  logic        clear_pend;
  logic        applied;

  assign cstall     = icache_stall | dcache_stall;
  assign ctrl_state = state;

  // Priority encode this cycle's request: trap(3) > mret(2) > br(1) > jmp(0).
  always_comb begin
    req        = 1'b1;
    req_prio   = 2'd0;
    req_target = jmp_target;
    if (trap_req) begin
      req_prio   = 2'd3;
      req_target = TRAP_VEC;
    end else if (mret_req) begin
      req_prio   = 2'd2;
      req_target = epc;
    end else if (br_taken) begin
      req_prio   = 2'd1;
      req_target = br_target;
    end else if (!jmp_valid) begin
      req = 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    new_pc     = pc_cur + 32'd4;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    latch_req  = 1'b0;
    clear_pend = 1'b0;
    applied    = 1'b0;
    if (!rst) begin
      new_pc    = RESET_PC;
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!req) begin
            pc_write = !(hazard_stall | cstall);
          end else if (cstall) begin
            latch_req = 1'b1;
            state_nxt = HOLD;
          end else begin
            applied  = 1'b1;
            pc_write = 1'b1;
            new_pc   = req_target;
            flush_if = 1'b1;
            flush_id = (req_prio != 2'd0);
          end
        end
        HOLD: begin
          if (cstall) begin
            latch_req = req && (!pend_valid || req_prio >= pend_prio);
          end else begin
            applied    = 1'b1;
            pc_write   = 1'b1;
            flush_if   = 1'b1;
            clear_pend = 1'b1;
            state_nxt  = RUN;
            // A fresh request wins ties against the buffered one.
            if (req && (!pend_valid || req_prio >= pend_prio)) begin
              new_pc   = req_target;
              flush_id = (req_prio != 2'd0);
            end else begin
              new_pc   = pend_target;
              flush_id = (pend_prio != 2'd0);
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
      pend_prio   <= 2'd0;
      epc         <= 32'd0;
      mcause      <= 4'd0;
    end else begin
      state <= state_nxt;
      if (latch_req) begin
        pend_valid  <= 1'b1;
        pend_target <= req_target;
        pend_prio   <= req_prio;
      end else if (clear_pend) begin
        pend_valid <= 1'b0;
      end
      if (trap_req) begin
        epc    <= trap_epc;
        mcause <= trap_cause;
      end
    end
  end

`ifdef NEXT_PC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_cnt <= 32'd0;
      stall_cnt    <= 32'd0;
    end else begin
      if (applied && redirect_cnt != 32'hFFFF_FFFF) redirect_cnt <= redirect_cnt + 32'd1;
      if (!pc_write && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  logic unused_applied;
  assign unused_applied = applied;
`endif

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Bench for next_pc_ctrl: directed scenarios plus randomized traffic against a
// candidate-list reference model of the redirect rules.
module tb_next_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, hazard_stall, icache_stall, dcache_stall;
  logic [31:0] pc_cur, jmp_target, br_target, trap_epc;
  logic        jmp_valid, br_taken, trap_req, mret_req;
  logic [3:0]  trap_cause;
  logic        pc_write, flush_if, flush_id, ctrl_state;
  logic [31:0] new_pc, epc;
  logic [3:0]  mcause;
`ifdef NEXT_PC_PERF_CNT_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: buffered redirect plus trap CSRs.
  bit          m_pv;
  logic [31:0] m_pt;
  int          m_pp;
  logic [31:0] m_epc;
  logic [3:0]  m_mc;
  logic [31:0] m_rc, m_sc;

  next_pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall), .pc_cur(pc_cur),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .br_taken(br_taken),
    .br_target(br_target), .trap_req(trap_req), .trap_epc(trap_epc),
    .trap_cause(trap_cause), .mret_req(mret_req), .pc_write(pc_write),
    .new_pc(new_pc), .flush_if(flush_if), .flush_id(flush_id), .epc(epc),
    .mcause(mcause), .ctrl_state(ctrl_state)
`ifdef NEXT_PC_PERF_CNT_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    hazard_stall = 0; icache_stall = 0; dcache_stall = 0;
    jmp_valid = 0; br_taken = 0; trap_req = 0; mret_req = 0;
    jmp_target = 0; br_target = 0; trap_epc = 0; trap_cause = 0;
  endtask

  // Evaluate the model for the current inputs, compare, then advance one clock.
  task automatic step();
    logic [31:0] cand_t[4];
    bit          cand_v[4];
    int          win;
    bit          cst, e_pw, e_fi, e_fd, apply_flag;
    logic [31:0] e_new;
    bit          n_pv;
    logic [31:0] n_pt, n_epc, n_rc, n_sc;
    int          n_pp;
    logic [3:0]  n_mc;
    #1;
    cand_v[0] = jmp_valid; cand_t[0] = jmp_target;
    cand_v[1] = br_taken;  cand_t[1] = br_target;
    cand_v[2] = mret_req;  cand_t[2] = m_epc;
    cand_v[3] = trap_req;  cand_t[3] = TRAP_VEC;
    win = -1;
    for (int i = 0; i < 4; i++) if (cand_v[i]) win = i;
    cst = icache_stall | dcache_stall;
    e_new = pc_cur + 32'd4; e_pw = 0; e_fi = 0; e_fd = 0; apply_flag = 0;
    n_pv = m_pv; n_pt = m_pt; n_pp = m_pp; n_epc = m_epc; n_mc = m_mc;
    n_rc = m_rc; n_sc = m_sc;
    if (!rst) begin
      e_new = RESET_PC; n_pv = 0; n_epc = 0; n_mc = 0; n_rc = 0; n_sc = 0;
    end else begin
      if (trap_req) begin n_epc = trap_epc; n_mc = trap_cause; end
      if (!m_pv) begin
        if (win < 0) e_pw = !(hazard_stall | cst);
        else if (cst) begin n_pv = 1; n_pt = cand_t[win]; n_pp = win; end
        else begin e_pw = 1; e_new = cand_t[win]; e_fi = 1; e_fd = (win != 0); apply_flag = 1; end
      end else if (cst) begin
        if (win >= 0 && win >= m_pp) begin n_pt = cand_t[win]; n_pp = win; end
      end else begin
        e_pw = 1; e_fi = 1; apply_flag = 1; n_pv = 0;
        if (win >= 0 && win >= m_pp) begin e_new = cand_t[win]; e_fd = (win != 0); end
        else begin e_new = m_pt; e_fd = (m_pp != 0); end
      end
      if (apply_flag && m_rc != 32'hFFFF_FFFF) n_rc = m_rc + 1;
      if (!e_pw && m_sc != 32'hFFFF_FFFF) n_sc = m_sc + 1;
    end
    check("pc_write", {31'd0, pc_write}, {31'd0, e_pw});
    check("new_pc", new_pc, e_new);
    check("flush_if", {31'd0, flush_if}, {31'd0, e_fi});
    check("flush_id", {31'd0, flush_id}, {31'd0, e_fd});
    check("epc", epc, m_epc);
    check("mcause", {28'd0, mcause}, {28'd0, m_mc});
    check("ctrl_state", {31'd0, ctrl_state}, {31'd0, m_pv});
`ifdef NEXT_PC_PERF_CNT_EN
    check("redirect_cnt", redirect_cnt, m_rc);
    check("stall_cnt", stall_cnt, m_sc);
`endif
    @(posedge clk);
    m_pv = n_pv; m_pt = n_pt; m_pp = n_pp; m_epc = n_epc; m_mc = n_mc;
    m_rc = n_rc; m_sc = n_sc;
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 0; step(); rst = 0; step(); rst = 1;
  endtask

  initial begin
    m_pv = 0; m_pt = 0; m_pp = 0; m_epc = 0; m_mc = 0; m_rc = 0; m_sc = 0;
    idle_inputs();
    pc_cur = 0;

    // 1: reset state and release
    rst = 0; #1;
    check("rst_pc_write", {31'd0, pc_write}, 32'd0);
    check("rst_flush_if", {31'd0, flush_if}, 32'd0);
    check("rst_flush_id", {31'd0, flush_id}, 32'd0);
    check("rst_new_pc", new_pc, RESET_PC);
    step();
    rst = 0; step();
    check("rst_epc", epc, 32'd0);
    check("rst_state", {31'd0, ctrl_state}, 32'd0);
    rst = 1; pc_cur = 0; #1;
    check("rel_new_pc", new_pc, 32'd4);
    check("rel_pc_write", {31'd0, pc_write}, 32'd1);
    step();

    // 2: branch applied same cycle
    pc_cur = 32'h100; br_taken = 1; br_target = 32'h40; #1;
    check("br_new_pc", new_pc, 32'h40);
    check("br_flush_if", {31'd0, flush_if}, 32'd1);
    check("br_flush_id", {31'd0, flush_id}, 32'd1);
    step();
    pc_cur = 32'h40; #1;
    check("br_flush_after", {31'd0, flush_if | flush_id}, 32'd0);
    step();

    // 3: branch buffered across a 3-cycle icache stall
    do_reset();
    pc_cur = 32'h100; icache_stall = 1; br_taken = 1; br_target = 32'h40; #1;
    check("hold_pc_write", {31'd0, pc_write}, 32'd0);
    step();
    check("hold_state", {31'd0, ctrl_state}, 32'd1);
    icache_stall = 1; step();
    icache_stall = 1; step();
    #1;
    check("replay_new_pc", new_pc, 32'h40);
    check("replay_pc_write", {31'd0, pc_write}, 32'd1);
    check("replay_flush", {30'd0, flush_if, flush_id}, 32'd3);
    step();
    check("replay_state", {31'd0, ctrl_state}, 32'd0);
`ifdef NEXT_PC_PERF_CNT_EN
    check("perf_stall_cnt", stall_cnt, 32'd3);
    check("perf_redirect_cnt", redirect_cnt, 32'd1);
`endif

    // 4: trap beats branch and jump; mret returns to epc
    pc_cur = 32'h200; trap_req = 1; trap_epc = 32'h200; trap_cause = 4'h2;
    br_taken = 1; br_target = 32'h40; jmp_valid = 1; jmp_target = 32'h80; #1;
    check("trap_new_pc", new_pc, TRAP_VEC);
    step();
    check("trap_epc", epc, 32'h200);
    check("trap_mcause", {28'd0, mcause}, 32'd2);
    pc_cur = TRAP_VEC; mret_req = 1; #1;
    check("mret_new_pc", new_pc, 32'h200);
    check("mret_flush_id", {31'd0, flush_id}, 32'd1);
    step();

    // 5: hazard stall alone, and overridden by a jump
    pc_cur = 32'h300; hazard_stall = 1; #1;
    check("haz_pc_write", {31'd0, pc_write}, 32'd0);
    step();
    hazard_stall = 1; jmp_valid = 1; jmp_target = 32'h80; #1;
    check("hazjmp_pc_write", {31'd0, pc_write}, 32'd1);
    check("hazjmp_new_pc", new_pc, 32'h80);
    check("hazjmp_flush", {30'd0, flush_if, flush_id}, 32'd2);
    step();

    // 6: sequential wrap
    pc_cur = 32'hFFFF_FFFC; #1;
    check("wrap_new_pc", new_pc, 32'd0);
    step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 60) != 0);
      pc_cur       = $urandom;
      hazard_stall = ($urandom_range(0, 4) == 0);
      icache_stall = ($urandom_range(0, 3) == 0);
      dcache_stall = ($urandom_range(0, 5) == 0);
      jmp_valid    = ($urandom_range(0, 5) == 0);
      jmp_target   = $urandom;
      br_taken     = ($urandom_range(0, 5) == 0);
      br_target    = $urandom;
      trap_req     = ($urandom_range(0, 9) == 0);
      trap_epc     = $urandom;
      trap_cause   = 4'($urandom_range(0, 15));
      mret_req     = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
